battleship_turn_ctrl: RTL and testbench
=======================================

BATTLESHIP_TURN_CTRL -- requirements
Module: battleship_turn_ctrl

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of players, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 0, SELECT-state turn timeout in clk cycles; 0 disables the timeout.
REQ-003 Parameter REDO_HOLD, default 1, cycles the error display is held in REDO, legal range 1..255.
REQ-004 Derived PW = max(1, clog2(NUM_PLAYERS)), player-index width.
REQ-005 Ports: clk in 1, system clock; one clock, all state on its rising edge.
REQ-006 Ports: clr_n in 1, reset, asynchronous, active-low.
REQ-007 Ports: start in 1, level, both/all players done placing ships.
REQ-008 Ports: fire in NUM_PLAYERS, level, per-player attack-commit button.
REQ-009 Ports: alive in NUM_PLAYERS, per-player "ships remaining" flag.
REQ-010 Ports: ok in 1, entry-checker verdict for the current attacker, valid in ATTACK.
REQ-011 Ports: st out 1, setup-phase indicator.
REQ-012 Ports: ld_ships out NUM_PLAYERS, ship-register load enable per player.
REQ-013 Ports: ld_attack out NUM_PLAYERS, attack-register load enable per player.
REQ-014 Ports: disp out 3*NUM_PLAYERS, display code per player, player i at bits [3i+2:3i].
REQ-015 Ports: cur_player out PW; target out PW; winner out PW; winner_valid out 1; timeout out 1; turn_count out 16.

Function
REQ-016 States SHALL be SETUP, SELECT, ATTACK, REDO, CHECK, WIN; outputs SHALL be Moore decodes of state, cur_player and target.
REQ-017 Display codes: 0 off, 1 selecting, 2 waiting, 5 error, 6 winner, 7 loser.
REQ-018 SETUP: st=1, ld_ships all 1, disp all 0; start=1 SHALL go to SELECT with cur_player=0.
REQ-019 target SHALL be the first index after cur_player, cyclically, with alive=1; it is recomputed combinationally.
REQ-020 SELECT: disp[cur]=1, others 2; fire[cur_player]=1 SHALL go to ATTACK; fire from any other player is ignored.
REQ-021 ATTACK (1 cycle): ld_attack[cur]=1, ld_ships[target]=1; ok=1 goes to CHECK, ok=0 goes to REDO.
REQ-022 REDO: disp[cur]=5, others 2, for exactly REDO_HOLD cycles; it then returns to SELECT with the same cur_player.
REQ-023 CHECK (1 cycle, alive is sampled here): turn_count SHALL increment, saturating at 16'hFFFF.
REQ-024 CHECK exit: if at most one alive bit is set, go to WIN; otherwise go to SELECT with cur_player set to the next alive index after cur_player.
REQ-025 WIN entry: winner is the single alive index; if none is alive, winner is the last attacker. winner_valid=1, disp[winner]=6, others 7.
REQ-026 WIN SHALL be held until clr_n is asserted; start is ignored in WIN.
REQ-027 Timeout (TIMEOUT_CYC>0): a counter SHALL clear on SELECT entry and count each SELECT cycle.
REQ-028 Timeout expiry: at count TIMEOUT_CYC-1 without fire, timeout SHALL pulse for 1 cycle and cur_player advances to the next alive index; state stays SELECT, the counter clears, and turn_count is unchanged.
REQ-029 If fire[cur] and expiry coincide, fire wins: go to ATTACK, no timeout pulse.
REQ-030 If alive[cur_player]=0 in SELECT, cur_player SHALL advance to the next alive index on the next cycle, with no timeout pulse.
REQ-031 Wrap-around: the index search SHALL wrap NUM_PLAYERS-1 to 0; indices ≥ NUM_PLAYERS are never produced.

Reset
REQ-032 clr_n=0 SHALL immediately force SETUP, cur_player=0, turn_count=0, timeout counter=0, REDO counter=0.
REQ-033 Output values during reset: winner=0, winner_valid=0, timeout=0, st=1, ld_ships all 1, ld_attack all 0, disp all 0.
REQ-034 Reset asserted mid-ATTACK or mid-REDO SHALL abandon the turn; no load enable may persist into the cycle after reset release.

Verification
REQ-035 NP=2, start=1 then fire[0]=1 with ok=1 -> ATTACK shows ld_attack=01, ld_ships=10; CHECK; SELECT with cur_player=1; turn_count=1.
REQ-036 NP=2, fire[0]=1 with ok=0, REDO_HOLD=3 -> disp[0]=5 for 3 cycles, then SELECT with cur_player=0; turn_count=0.
REQ-037 NP=4, alive=1011, cur=1 attack ok -> target=3; next cur_player=3; then attack from 3 -> target=0 (wrap).
REQ-038 NP=3, TIMEOUT_CYC=10, no fire -> timeout pulses on the 10th SELECT cycle; cur_player 0→1; turn_count unchanged. Fire on the 10th cycle -> ATTACK, no pulse.
REQ-039 NP=2, alive drops to 01 before CHECK -> WIN with winner=0, winner_valid=1, disp={7,6}; start=1 ignored; clr_n=0 -> SETUP outputs immediately.

Source files
------------

// File: rtl/battleship_turn_ctrl.sv
// Turn sequencer for an N-player battleship game: setup, per-player attack turns with
// entry retry, optional per-turn timeout, elimination check and winner display.
module battleship_turn_ctrl #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter int unsigned REDO_HOLD   = 1,
  localparam int unsigned PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       start,
  input  logic [NUM_PLAYERS-1:0]     fire,
  input  logic [NUM_PLAYERS-1:0]     alive,
  input  logic                       ok,
  output logic                       st,
  output logic [NUM_PLAYERS-1:0]     ld_ships,
  output logic [NUM_PLAYERS-1:0]     ld_attack,
  output logic [3*NUM_PLAYERS-1:0]   disp,
  output logic [PW-1:0]              cur_player,
  output logic [PW-1:0]              target,
  output logic [PW-1:0]              winner,
  output logic                       winner_valid,
  output logic                       timeout,
  output logic [15:0]                turn_count
);

  localparam logic [2:0] S_SETUP  = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_ATTACK = 3'd2;
  localparam logic [2:0] S_REDO   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_WIN    = 3'd5;

  localparam logic [2:0] D_OFF    = 3'd0;
  localparam logic [2:0] D_SEL    = 3'd1;
  localparam logic [2:0] D_WAIT   = 3'd2;
  localparam logic [2:0] D_ERR    = 3'd5;
  localparam logic [2:0] D_WINNER = 3'd6;
  localparam logic [2:0] D_LOSER  = 3'd7;

  logic [2:0]    r_state;
  logic [PW-1:0] r_cur;
  logic [PW-1:0] r_winner;
  logic [15:0]   r_turn_count;
  logic [31:0]   r_to_cnt;
  logic [7:0]    r_redo_cnt;

  logic [2:0]    w_state_nxt;
  logic [PW-1:0] w_cur_nxt;
  logic [PW-1:0] w_winner_nxt;
  logic [15:0]   w_turn_nxt;
  logic [31:0]   w_to_nxt;
  logic [7:0]    w_redo_nxt;

  logic [PW-1:0] w_target;
  logic          w_cur_alive;
  logic          w_cur_fire;
  logic          w_expire;
  logic          w_alive_le1;

  // First alive index after 'from', wrapping; 'from' itself is the last candidate, and it is
  // also returned when nobody is alive.
  function automatic logic [PW-1:0] f_next_alive(input logic [PW-1:0]          from,
                                                 input logic [NUM_PLAYERS-1:0] mask);
    logic [PW-1:0] res;
    logic [PW-1:0] idx;
    logic          found;
    res   = from;
    idx   = from;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_PLAYERS; k++) begin
      idx = (idx == PW'(NUM_PLAYERS - 1)) ? '0 : idx + 1'b1;
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [3*NUM_PLAYERS-1:0] f_disp(input logic [PW-1:0] who,
                                                      input logic [2:0]    hi,
                                                      input logic [2:0]    lo);
    logic [3*NUM_PLAYERS-1:0] res;
    res = '0;
    for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
      res[3*i +: 3] = (PW'(i) == who) ? hi : lo;
    end
    return res;
  endfunction

  assign w_target    = f_next_alive(r_cur, alive);
  assign w_cur_alive = alive[r_cur];
  assign w_cur_fire  = fire[r_cur];
  assign w_alive_le1 = ((alive & (alive - NUM_PLAYERS'(1))) == '0);

  // A dead current player or a fire press both pre-empt the timeout.
  assign w_expire = (TIMEOUT_CYC != 0) && (r_state == S_SELECT) && w_cur_alive && !w_cur_fire &&
                    (r_to_cnt == TIMEOUT_CYC - 32'd1);

  always_comb begin
    w_state_nxt  = r_state;
    w_cur_nxt    = r_cur;
    w_winner_nxt = r_winner;
    w_turn_nxt   = r_turn_count;
    w_to_nxt     = '0;
    w_redo_nxt   = r_redo_cnt;
    case (r_state)
      S_SETUP: begin
        if (start) begin
          w_state_nxt = S_SELECT;
          w_cur_nxt   = '0;
        end
      end
      S_SELECT: begin
        if (!w_cur_alive) begin
          w_cur_nxt = w_target;
        end else if (w_cur_fire) begin
          w_state_nxt = S_ATTACK;
        end else if (w_expire) begin
          w_cur_nxt = w_target;
        end else if (TIMEOUT_CYC != 0) begin
          w_to_nxt = r_to_cnt + 32'd1;
        end
      end
      S_ATTACK: begin
        w_redo_nxt  = '0;
        w_state_nxt = ok ? S_CHECK : S_REDO;
      end
      S_REDO: begin
        if (r_redo_cnt == 8'(REDO_HOLD - 1)) begin
          w_state_nxt = S_SELECT;
        end else begin
          w_redo_nxt = r_redo_cnt + 8'd1;
        end
      end
      S_CHECK: begin
        w_turn_nxt = (r_turn_count == 16'hFFFF) ? r_turn_count : r_turn_count + 16'd1;
        if (w_alive_le1) begin
          w_state_nxt  = S_WIN;
          w_winner_nxt = w_target;
        end else begin
          w_state_nxt = S_SELECT;
          w_cur_nxt   = w_target;
        end
      end
      S_WIN: begin
        w_state_nxt = S_WIN;
      end
      default: begin
        w_state_nxt = S_SETUP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state      <= S_SETUP;
      r_cur        <= '0;
      r_winner     <= '0;
      r_turn_count <= '0;
      r_to_cnt     <= '0;
      r_redo_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur        <= w_cur_nxt;
      r_winner     <= w_winner_nxt;
      r_turn_count <= w_turn_nxt;
      r_to_cnt     <= w_to_nxt;
      r_redo_cnt   <= w_redo_nxt;
    end
  end

  always_comb begin
    st           = 1'b0;
    ld_ships     = '0;
    ld_attack    = '0;
    disp         = '0;
    winner_valid = 1'b0;
    case (r_state)
      S_SETUP: begin
        st       = 1'b1;
        ld_ships = '1;
        disp     = f_disp(r_cur, D_OFF, D_OFF);
      end
      S_SELECT, S_CHECK: begin
        disp = f_disp(r_cur, D_SEL, D_WAIT);
      end
      S_ATTACK: begin
        ld_attack[r_cur]   = 1'b1;
        ld_ships[w_target] = 1'b1;
        disp               = f_disp(r_cur, D_SEL, D_WAIT);
      end
      S_REDO: begin
        disp = f_disp(r_cur, D_ERR, D_WAIT);
      end
      S_WIN: begin
        winner_valid = 1'b1;
        disp         = f_disp(r_winner, D_WINNER, D_LOSER);
      end
      default: begin
        st       = 1'b1;
        ld_ships = '1;
      end
    endcase
  end

  assign cur_player = r_cur;
  assign target     = w_target;
  assign winner     = r_winner;
  assign timeout    = w_expire;
  assign turn_count = r_turn_count;

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Bench for battleship_turn_ctrl: a game-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_battleship_turn_ctrl;
  localparam int NP = 4;
  localparam int TO = 10;
  localparam int RH = 3;

  logic        clk   = 1'b0;
  logic        clr_n = 1'b1;
  logic        start = 1'b0;
  logic        ok    = 1'b0;
  logic [3:0]  fire  = 4'b0000;
  logic [3:0]  alive = 4'b0011;

  logic        st;
  logic [3:0]  ld_ships;
  logic [3:0]  ld_attack;
  logic [11:0] disp;
  logic [1:0]  cur_player;
  logic [1:0]  target;
  logic [1:0]  winner;
  logic        winner_valid;
  logic        timeout;
  logic [15:0] turn_count;

  always #5 clk = ~clk;

  battleship_turn_ctrl #(
    .NUM_PLAYERS(NP),
    .TIMEOUT_CYC(TO),
    .REDO_HOLD  (RH)
  ) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .start       (start),
    .fire        (fire),
    .alive       (alive),
    .ok          (ok),
    .st          (st),
    .ld_ships    (ld_ships),
    .ld_attack   (ld_attack),
    .disp        (disp),
    .cur_player  (cur_player),
    .target      (target),
    .winner      (winner),
    .winner_valid(winner_valid),
    .timeout     (timeout),
    .turn_count  (turn_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game-level reference model
  typedef enum int {MSetup, MSelect, MAttack, MRedo, MCheck, MWin} ph_t;
  ph_t m_ph        = MSetup;
  int  m_cur       = 0;
  int  m_sel       = 0;
  int  m_redo_left = 0;
  int  m_turns     = 0;
  int  m_win       = 0;

  function automatic int m_next(input int c, input logic [3:0] a);
    for (int d = 1; d <= NP; d++) begin
      if (a[(c + d) % NP]) return (c + d) % NP;
    end
    return c;
  endfunction

  function automatic int m_lone(input logic [3:0] a, input int dflt);
    int w = dflt;
    for (int i = 0; i < NP; i++) if (a[i]) w = i;
    return w;
  endfunction

  function automatic logic [11:0] m_disp(input int who, input int hi, input int lo);
    logic [11:0] d = '0;
    for (int i = 0; i < NP; i++) d[3*i +: 3] = (i == who) ? 3'(hi) : 3'(lo);
    return d;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_ph <= MSetup; m_cur <= 0; m_sel <= 0; m_redo_left <= 0; m_turns <= 0; m_win <= 0;
    end else begin
      case (m_ph)
        MSetup: if (start) begin m_ph <= MSelect; m_cur <= 0; m_sel <= 0; end
        MSelect: begin
          if (!alive[m_cur]) begin
            m_cur <= m_next(m_cur, alive); m_sel <= 0;
          end else if (fire[m_cur]) begin
            m_ph <= MAttack;
          end else if (m_sel == TO - 1) begin
            m_cur <= m_next(m_cur, alive); m_sel <= 0;
          end else begin
            m_sel <= m_sel + 1;
          end
        end
        MAttack: begin
          if (ok) m_ph <= MCheck;
          else begin m_ph <= MRedo; m_redo_left <= RH; end
        end
        MRedo: begin
          if (m_redo_left == 1) begin m_ph <= MSelect; m_sel <= 0; end
          else m_redo_left <= m_redo_left - 1;
        end
        MCheck: begin
          m_turns <= (m_turns == 65535) ? 65535 : m_turns + 1;
          if ($countones(alive) <= 1) begin
            m_ph <= MWin; m_win <= m_lone(alive, m_cur);
          end else begin
            m_ph <= MSelect; m_cur <= m_next(m_cur, alive); m_sel <= 0;
          end
        end
        default: ;
      endcase
    end
  end

  logic [3:0]  e_lds, e_lda;
  logic [11:0] e_disp;
  logic        e_to;
  int          e_tgt;

  always @(negedge clk) begin
    if (chk_en) begin
      e_tgt  = m_next(m_cur, alive);
      e_lds  = (m_ph == MSetup) ? 4'hF : (m_ph == MAttack) ? 4'(1 << e_tgt) : 4'h0;
      e_lda  = (m_ph == MAttack) ? 4'(1 << m_cur) : 4'h0;
      e_to   = (m_ph == MSelect) && alive[m_cur] && !fire[m_cur] && (m_sel == TO - 1);
      case (m_ph)
        MSetup:  e_disp = 12'h000;
        MRedo:   e_disp = m_disp(m_cur, 5, 2);
        MWin:    e_disp = m_disp(m_win, 6, 7);
        default: e_disp = m_disp(m_cur, 1, 2);
      endcase
      check("m_st", st, (m_ph == MSetup));
      check("m_ld_ships", ld_ships, e_lds);
      check("m_ld_attack", ld_attack, e_lda);
      check("m_disp", disp, e_disp);
      check("m_cur_player", cur_player, m_cur);
      check("m_target", target, e_tgt);
      check("m_winner", winner, m_win);
      check("m_winner_valid", winner_valid, (m_ph == MWin));
      check("m_timeout", timeout, e_to);
      check("m_turn_count", turn_count, m_turns);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #2 clr_n = 1'b0;
    #1 chk_en = 1'b1;
    tick(); tick();
    check("rst_st", st, 1); check("rst_lds", ld_ships, 4'hF); check("rst_disp", disp, 0);
    check("rst_wv", winner_valid, 0); check("rst_turns", turn_count, 0);

    // Two live players: normal turn from player 0
    clr_n = 1'b1; start = 1'b1; alive = 4'b0011; tick(); start = 1'b0;
    check("sel_cur0", cur_player, 0); check("sel_disp0", disp, 12'h491);
    fire = 4'b0001; ok = 1'b1; tick();
    check("atk_lda", ld_attack, 4'b0001); check("atk_lds", ld_ships, 4'b0010);
    fire = 4'b0000; tick(); tick();
    check("chk_cur1", cur_player, 1); check("chk_turns1", turn_count, 1);

    // Fire from a non-current player is ignored; then a rejected entry
    fire = 4'b0001; tick();
    check("ign_lda", ld_attack, 0); check("ign_cur", cur_player, 1);
    fire = 4'b0010; ok = 1'b0; tick(); fire = 4'b0000; tick();
    for (int i = 0; i < RH; i++) begin
      check("redo_disp", disp, 12'h4AA); tick();
    end
    check("redo_back_disp", disp, 12'h48A); check("redo_back_cur", cur_player, 1);
    check("redo_turns", turn_count, 1);

    // Skip a dead player, then wrap from 3 to 0
    alive = 4'b1011; #1 check("tgt3", target, 3);
    fire = 4'b0010; ok = 1'b1; tick(); check("atk_lds3", ld_ships, 4'b1000);
    fire = 4'b0000; tick(); tick();
    check("cur3", cur_player, 3); check("tgt_wrap", target, 0); check("turns2", turn_count, 2);
    fire = 4'b1000; tick();
    check("wrap_lds", ld_ships, 4'b0001); check("wrap_lda", ld_attack, 4'b1000);
    fire = 4'b0000; tick(); tick();
    check("cur0", cur_player, 0); check("turns3", turn_count, 3);

    // Timeout on the 10th SELECT cycle
    repeat (9) tick();
    check("to_pulse", timeout, 1); check("to_cur_before", cur_player, 0);
    tick();
    check("to_clear", timeout, 0); check("to_cur_after", cur_player, 1);
    check("to_turns", turn_count, 3);
    repeat (9) tick();
    fire = 4'b0010; #1 check("to_fire_wins", timeout, 0);
    tick(); check("to_fire_lda", ld_attack, 4'b0010);
    fire = 4'b0000; tick(); tick();
    check("cur3b", cur_player, 3); check("turns4", turn_count, 4);

    // Current player died while selecting
    alive = 4'b0111; tick(); check("dead_skip", cur_player, 0);

    // Last survivor wins
    alive = 4'b0011; fire = 4'b0001; tick(); fire = 4'b0000; alive = 4'b0001; tick(); tick();
    check("win_idx", winner, 0); check("win_valid", winner_valid, 1);
    check("win_disp", disp, 12'hFFE); check("win_turns", turn_count, 5);
    start = 1'b1; tick(); tick(); start = 1'b0;
    check("win_hold", winner_valid, 1); check("win_st", st, 0);
    clr_n = 1'b0; #1;
    check("clr_st", st, 1); check("clr_lds", ld_ships, 4'hF); check("clr_disp", disp, 0);
    check("clr_wv", winner_valid, 0); check("clr_winner", winner, 0);

    // Reset mid-ATTACK abandons the turn
    tick(); clr_n = 1'b1; alive = 4'b1111; start = 1'b1; tick(); start = 1'b0;
    fire = 4'b0001; ok = 1'b1; tick(); check("mid_lda", ld_attack, 4'b0001);
    clr_n = 1'b0; #1 check("mid_rst_lda", ld_attack, 0);
    tick(); clr_n = 1'b1; fire = 4'b0000; tick();
    check("post_rst_lda", ld_attack, 0); check("post_rst_st", st, 1);

    // Nobody left: last attacker is the winner
    start = 1'b1; tick(); start = 1'b0;
    fire = 4'b0001; tick(); fire = 4'b0000; tick(); tick();
    fire = 4'b0010; tick(); fire = 4'b0000; alive = 4'b0000; tick(); tick();
    check("none_winner", winner, 1); check("none_wv", winner_valid, 1);
    check("none_disp", disp, 12'hFF7); check("none_turns", turn_count, 2);
    check("model_win", m_win, 1);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
